// File: rtl/rgb_to_hsv_seq_if.sv
// Handshake bundle for the RGB-to-HSV converter.
// Valid/ready semantics on both sides: a transfer happens on a rising clk edge
// where valid and ready are both 1. A source holds valid and its data stable
// until that edge, and valid never depends on ready. The converter raises
// in_ready only when idle and holds out_valid with stable hsv_* until accepted.
interface rgb_to_hsv_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_r;
    logic [7:0] in_g;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] hsv_h;
    logic [8:0] hsv_s;
    logic [8:0] hsv_v;

    modport master (
        output in_valid, in_r, in_g, in_b, out_ready,
        input  in_ready, out_valid, hsv_h, hsv_s, hsv_v
    );

    modport slave (
        input  in_valid, in_r, in_g, in_b, out_ready,
        output in_ready, out_valid, hsv_h, hsv_s, hsv_v
    );
endinterface

// File: rtl/rgb_to_hsv_seq.sv
// Sequential RGB888 -> HSV converter built around one shared 8-step restoring
// divider. Saturation is divided first, then hue; both take exactly 8 cycles so
// latency is data independent (2 edges for grey inputs, 18 edges otherwise).
module rgb_to_hsv_seq #(
    parameter int HUE_SECTOR = 60,
    parameter int SAT_SCALE  = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    rgb_to_hsv_seq_if.slave        bus,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_DIV_S = 3'd2,
        S_DIV_H = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SRC_R = 2'd0,
        SRC_G = 2'd1,
        SRC_B = 2'd2
    } src_t;

    localparam logic [8:0] HUE_G    = 9'(2 * HUE_SECTOR);
    localparam logic [8:0] HUE_B    = 9'(4 * HUE_SECTOR);
    localparam logic [8:0] HUE_FULL = 9'(6 * HUE_SECTOR);

    state_t     state, state_nxt;

    // Latched pixel; stays constant for the whole conversion.
    logic [7:0] r_q, g_q, b_q;

    // Divider: rem_q is the running remainder, lo_q shifts in the low
    // dividend bits and collects quotient bits, MSB first.
    logic [7:0] rem_q;
    logic [7:0] lo_q;
    logic [7:0] div_q;
    logic [2:0] cnt_q;
    logic [7:0] sat_q;

    logic       out_valid_q;
    logic [8:0] h_q, s_q, v_q;

    // Combinational view of the latched pixel.
    src_t       src_v;
    logic [7:0] max_v, min_v, delta_v, absnum_v;
    logic       pos_v;
    logic [15:0] sat_dvd, hue_dvd;

    // Divider step signals; trial is the 9-bit partial remainder.
    logic [8:0] trial;
    logic       ge;
    logic [7:0] rem_nxt;
    logic [7:0] q_nxt;
    logic [8:0] hue_v;

    // Max/min/delta, hue source (R before G before B on ties) and hue numerator.
    always_comb begin
        src_v    = SRC_B;
        max_v    = b_q;
        pos_v    = (r_q >= g_q);
        absnum_v = pos_v ? (r_q - g_q) : (g_q - r_q);
        if (r_q >= g_q && r_q >= b_q) begin
            src_v    = SRC_R;
            max_v    = r_q;
            pos_v    = (g_q >= b_q);
            absnum_v = pos_v ? (g_q - b_q) : (b_q - g_q);
        end else if (g_q >= b_q) begin
            src_v    = SRC_G;
            max_v    = g_q;
            pos_v    = (b_q >= r_q);
            absnum_v = pos_v ? (b_q - r_q) : (r_q - b_q);
        end
        min_v = r_q;
        if (g_q < min_v) min_v = g_q;
        if (b_q < min_v) min_v = b_q;
        delta_v = max_v - min_v;
        sat_dvd = 16'(SAT_SCALE) * 16'(delta_v);
        hue_dvd = 16'(HUE_SECTOR) * 16'(absnum_v);
    end

    // One restoring-division step: shift in a dividend bit, subtract if it fits.
    always_comb begin
        trial   = {rem_q, lo_q[7]};
        ge      = (trial >= {1'b0, div_q});
        rem_nxt = ge ? 8'(trial - {1'b0, div_q}) : trial[7:0];
        q_nxt   = {lo_q[6:0], ge};
    end

    // Final hue from the sector quotient held in lo_q (0..60).
    always_comb begin
        hue_v = 9'd0;
        case (src_v)
            SRC_R: begin
                if (pos_v || lo_q == 8'd0) hue_v = {1'b0, lo_q};
                else                       hue_v = HUE_FULL - {1'b0, lo_q};
            end
            SRC_G:   hue_v = pos_v ? (HUE_G + {1'b0, lo_q}) : (HUE_G - {1'b0, lo_q});
            default: hue_v = pos_v ? (HUE_B + {1'b0, lo_q}) : (HUE_B - {1'b0, lo_q});
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.in_valid) state_nxt = S_CALC;
            S_CALC:  state_nxt = (delta_v == 8'd0) ? S_OUT : S_DIV_S;
            S_DIV_S: if (cnt_q == 3'd7) state_nxt = S_DIV_H;
            S_DIV_H: if (cnt_q == 3'd7) state_nxt = S_OUT;
            S_OUT:   if (out_valid_q && bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs: ready only while idle, result registers drive the hsv bus.
    always_comb begin
        bus.in_ready  = (state == S_IDLE);
        bus.out_valid = out_valid_q;
        bus.hsv_h     = h_q;
        bus.hsv_s     = s_q;
        bus.hsv_v     = v_q;
        dbg_state     = state;
    end

    // Datapath: latch pixel, run the two divisions, publish the result once in OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= 8'd0;
            g_q         <= 8'd0;
            b_q         <= 8'd0;
            rem_q       <= 8'd0;
            lo_q        <= 8'd0;
            div_q       <= 8'd0;
            cnt_q       <= 3'd0;
            sat_q       <= 8'd0;
            out_valid_q <= 1'b0;
            h_q         <= 9'd0;
            s_q         <= 9'd0;
            v_q         <= 9'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_q <= bus.in_r;
                        g_q <= bus.in_g;
                        b_q <= bus.in_b;
                    end
                end
                S_CALC: begin
                    cnt_q <= 3'd0;
                    if (delta_v != 8'd0) begin
                        rem_q <= sat_dvd[15:8];
                        lo_q  <= sat_dvd[7:0];
                        div_q <= max_v;
                    end
                end
                S_DIV_S: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        sat_q <= q_nxt;
                        rem_q <= hue_dvd[15:8];
                        lo_q  <= hue_dvd[7:0];
                        div_q <= delta_v;
                    end else begin
                        rem_q <= rem_nxt;
                        lo_q  <= q_nxt;
                    end
                end
                S_DIV_H: begin
                    cnt_q <= cnt_q + 3'd1;
                    rem_q <= rem_nxt;
                    lo_q  <= q_nxt;
                end
                S_OUT: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        v_q         <= {1'b0, max_v};
                        if (delta_v == 8'd0) begin
                            h_q <= 9'd0;
                            s_q <= 9'd0;
                        end else begin
                            h_q <= hue_v;
                            s_q <= {1'b0, sat_q};
                        end
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
